operand_fetch: RTL and testbench

Operand-fetch stage between instruction decode and execute. Accepts a decoded instruction over a valid/ready handshake and drives the register-file read addresses. Captures both source operands, including the register file's same-cycle write bypass, into an output pipeline register for execute. A per-register scoreboard stalls issue while an older instruction's write to a source or destination register is still outstanding.

---
 rtl/operand_fetch.sv | 108 ++++++++++
 tb/tb_operand_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file read, operand capture into an output register for execute,
// and an optional per-register busy scoreboard enabled by OPFETCH_SCOREBOARD_EN.
module operand_fetch #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OP_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_en,
    input  logic [XLEN-1:0] in_imm,
    input  logic [OP_W-1:0] in_op,
    output logic [4:0]      rf_rdAddrA,
    output logic [4:0]      rf_rdAddrB,
    input  logic [XLEN-1:0] rf_rdDataA,
    input  logic [XLEN-1:0] rf_rdDataB,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_imm,
    output logic [OP_W-1:0] out_op,
    output logic [4:0]      out_rd,
    output logic            out_rd_en,
    output logic [31:0]     sb_busy
);
    localparam int unsigned NREG = 32;

    logic [NREG-1:0] sb_q;
    logic            hazard;
    logic            accept;

    assign rf_rdAddrA = in_rs1;
    assign rf_rdAddrB = in_rs2;

`ifdef OPFETCH_SCOREBOARD_EN
    logic [NREG-1:0] sb_next;
    logic            rs1_haz;
    logic            rs2_haz;
    logic            waw_haz;

    // A writeback landing this cycle resolves the hazard via the register-file bypass.
    always_comb begin
        rs1_haz = (in_rs1 != 5'd0) && sb_q[in_rs1] && !(wb_valid && (wb_rd == in_rs1));
        rs2_haz = (in_rs2 != 5'd0) && sb_q[in_rs2] && !(wb_valid && (wb_rd == in_rs2));
        waw_haz = in_rd_en && (in_rd != 5'd0) && sb_q[in_rd] && !(wb_valid && (wb_rd == in_rd));
        hazard  = rs1_haz || rs2_haz || waw_haz;
    end

    // Clear on writeback first, then set on issue so a same-register collision leaves the bit set.
    always_comb begin
        sb_next = sb_q;
        if (wb_valid) begin
            sb_next[wb_rd] = 1'b0;
        end
        if (accept && in_rd_en && (in_rd != 5'd0)) begin
            sb_next[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_next;
        end
    end
`else
    logic unused_wb;

    assign unused_wb = &{1'b0, wb_valid, wb_rd};
    assign hazard    = 1'b0;
    assign sb_q      = '0;
`endif

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign sb_busy  = sb_q;

    // Output pipeline register; data holds its last value after a drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_imm   <= '0;
            out_op    <= '0;
            out_rd    <= '0;
            out_rd_en <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= (in_rs1 == 5'd0) ? '0 : rf_rdDataA;
            out_b     <= (in_rs2 == 5'd0) ? '0 : rf_rdDataB;
            out_imm   <= in_imm;
            out_op    <= in_op;
            out_rd    <= in_rd;
            out_rd_en <= in_rd_en;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written hazard sequences, and randomized
// traffic checked against a register-set reference model. Follows OPFETCH_SCOREBOARD_EN.
module tb_operand_fetch;
    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 8;
`ifdef OPFETCH_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready;
    logic [4:0]      in_rs1, in_rs2, in_rd;
    logic            in_rd_en;
    logic [XLEN-1:0] in_imm;
    logic [OP_W-1:0] in_op;
    logic [4:0]      rf_rdAddrA, rf_rdAddrB;
    logic [XLEN-1:0] rf_rdDataA, rf_rdDataB;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_a, out_b, out_imm;
    logic [OP_W-1:0] out_op;
    logic [4:0]      out_rd;
    logic            out_rd_en;
    logic [31:0]     sb_busy;

    logic [XLEN-1:0] rf [32];

    always #5 clk = ~clk;

    // Register file with same-cycle write bypass.
    assign rf_rdDataA = (wb_valid && (wb_rd == rf_rdAddrA)) ? wb_data : rf[rf_rdAddrA];
    assign rf_rdDataB = (wb_valid && (wb_rd == rf_rdAddrB)) ? wb_data : rf[rf_rdAddrB];

    operand_fetch #(.XLEN(XLEN), .OP_W(OP_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_en(in_rd_en),
        .in_imm(in_imm), .in_op(in_op),
        .rf_rdAddrA(rf_rdAddrA), .rf_rdAddrB(rf_rdAddrB),
        .rf_rdDataA(rf_rdDataA), .rf_rdDataB(rf_rdDataB),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_op(out_op),
        .out_rd(out_rd), .out_rd_en(out_rd_en), .sb_busy(sb_busy)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model: set of registers with an outstanding write, plus the expected bundle.
    bit              m_pend [32];
    bit              m_ov, m_rd_en, m_acc;
    logic [XLEN-1:0] m_a, m_b, m_imm;
    logic [OP_W-1:0] m_op;
    logic [4:0]      m_rd;

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_en;
        logic [31:0] imm;
        logic [7:0]  op;
        logic        ordy, wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        e_ready, e_ov;
        logic [31:0] e_a, e_b, e_busy;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_blocked(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r] && !(wb_valid && (wb_rd == r));
    endfunction

    function automatic bit m_ready();
        bit haz;
        haz = SB && (m_blocked(in_rs1) || m_blocked(in_rs2) || (in_rd_en && m_blocked(in_rd)));
        return (!m_ov || out_ready) && !haz;
    endfunction

    function automatic logic [XLEN-1:0] m_opnd(input logic [4:0] r);
        if (r == 5'd0) return '0;
        if (wb_valid && (wb_rd == r)) return wb_data;
        return rf[r];
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) if (m_pend[i]) b = b | (32'd1 << i);
        return b;
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            m_ov = 0; m_a = '0; m_b = '0; m_imm = '0; m_op = '0; m_rd = '0; m_rd_en = 0;
            m_acc = 0;
        end else begin
            m_acc = in_valid && m_ready();
            if (SB && wb_valid) m_pend[wb_rd] = 1'b0;
            if (SB && m_acc && in_rd_en && (in_rd != 5'd0)) m_pend[in_rd] = 1'b1;
            if (m_acc) begin
                m_ov = 1; m_a = m_opnd(in_rs1); m_b = m_opnd(in_rs2);
                m_imm = in_imm; m_op = in_op; m_rd = in_rd; m_rd_en = in_rd_en;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
        end
    endtask

    // Mid-cycle checks of the combinational outputs.
    task automatic pre();
        #4;
        chk("rf_rdAddrA", 32'(rf_rdAddrA), 32'(in_rs1));
        chk("rf_rdAddrB", 32'(rf_rdAddrB), 32'(in_rs2));
        if (!reset) chk("in_ready", 32'(in_ready), 32'(m_ready()));
    endtask

    // Clock edge, model update, then checks of the registered outputs.
    task automatic step_edge();
        @(posedge clk);
        model_edge();
        #1;
        if (wb_valid && (wb_rd != 5'd0)) rf[wb_rd] = wb_data;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_a", out_a, m_a);
        chk("out_b", out_b, m_b);
        chk("out_imm", out_imm, m_imm);
        chk("out_op", 32'(out_op), 32'(m_op));
        chk("out_rd", 32'(out_rd), 32'(m_rd));
        chk("out_rd_en", 32'(out_rd_en), 32'(m_rd_en));
        chk("sb_busy", sb_busy, m_busy());
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rd_en, input logic ordy,
                         input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_en = rd_en;
        out_ready = ordy; wb_valid = wbv; wb_rd = wbrd; wb_data = wbd;
    endtask

    initial begin
        bit hold;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
        rf[0] = 32'hFFFF_FFFF; rf[3] = 32'h11; rf[4] = 32'h22;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_ov = 0; m_acc = 0;

        //            v  rs1 rs2 rd en imm    op     ordy wbv wbrd wbd  rdy ov a       b       busy
        vt[0] = '{1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 32'h7, 8'h5A, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b1, 1'b1, 32'h11, 32'h22, SB ? 32'h20 : 32'h0};
        for (int i = 1; i <= 4; i++)
            vt[i] = '{1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 32'h9, 8'h33, 1'b0, 1'b0, 5'd0, 32'h0,
                      1'b0, 1'b1, 32'h11, 32'h22, SB ? 32'h20 : 32'h0};
        vt[5] = '{1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 32'h9, 8'h33, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b1, 1'b1, 32'h1001, 32'h1002, SB ? 32'h20 : 32'h0};
        vt[6] = '{1'b1, 5'd0, 5'd3, 5'd0, 1'b1, 32'h0, 8'h01, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b1, 1'b1, 32'h0, 32'h11, SB ? 32'h20 : 32'h0};
        vt[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b1, 1'b0, 32'h0, 32'h11, SB ? 32'h20 : 32'h0};

        // Reset held two cycles with a valid instruction waiting.
        reset = 1'b1; in_imm = 32'h7; in_op = 8'h5A;
        drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            pre(); step_edge();
            chk("reset out_valid", 32'(out_valid), 32'h0);
            chk("reset sb_busy", sb_busy, 32'h0);
        end
        reset = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].rd_en, vt[i].ordy,
                  vt[i].wbv, vt[i].wbrd, vt[i].wbd);
            in_imm = vt[i].imm; in_op = vt[i].op;
            pre();
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vt[i].e_ready));
            step_edge();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("vec%0d out_a", i), out_a, vt[i].e_a);
            chk($sformatf("vec%0d out_b", i), out_b, vt[i].e_b);
            chk($sformatf("vec%0d sb_busy", i), sb_busy, vt[i].e_busy);
        end

`ifdef OPFETCH_SCOREBOARD_EN
        // RAW stall on x5 until its writeback, which is bypassed into the operand.
        in_imm = 32'h3; in_op = 8'h44;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd5, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
            pre();
            chk("raw stall in_ready", 32'(in_ready), 32'h0);
            step_edge();
        end
        drive(1'b1, 5'd5, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 5'd5, 32'hAB);
        pre();
        chk("raw release in_ready", 32'(in_ready), 32'h1);
        step_edge();
        chk("raw bypass out_a", out_a, 32'hAB);
        chk("raw sb_busy", sb_busy, 32'h0);
        // Set/clear collision on x6, then a WAW resolved by a same-cycle writeback.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 32'h66);
            pre();
            chk("collision in_ready", 32'(in_ready), 32'h1);
            step_edge();
            chk("collision sb_busy", sb_busy, 32'h40);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h67);
        pre(); step_edge();
        chk("wb clear sb_busy", sb_busy, 32'h0);
`else
        // Without a scoreboard, a dependent pair issues back to back.
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        pre();
        chk("b2b first in_ready", 32'(in_ready), 32'h1);
        step_edge();
        drive(1'b1, 5'd7, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        pre();
        chk("b2b second in_ready", 32'(in_ready), 32'h1);
        step_edge();
        chk("b2b out_valid", 32'(out_valid), 32'h1);
        chk("b2b out_a", out_a, 32'h1007);
        chk("b2b sb_busy", sb_busy, 32'h0);
`endif

        // Randomized traffic; a waiting instruction keeps its fields until accepted.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        pre(); step_edge();
        hold = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_rs1   = 5'($urandom_range(0, 7));
                in_rs2   = 5'($urandom_range(0, 7));
                in_rd    = 5'($urandom_range(0, 7));
                in_rd_en = 1'($urandom_range(0, 1));
                in_imm   = $urandom;
                in_op    = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 9) < 4);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            reset     = ($urandom_range(0, 499) == 0);
            pre(); step_edge();
            hold = in_valid && !m_acc;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
